dvp_frame_ctrl: RTL and testbench
=================================

// Module: dvp_frame_ctrl
// PURPOSE
// - Frame-aware successor of the DVP RX gate: sits between the pixel-info FIFO and the pixel pipeline.
// - Tracks VSYNC/HSYNC per entry, packs BYTES_PER_PXL DVP bytes into one pixel and checks line/frame geometry.
// - Supports continuous, single-frame (snapshot) and frame-skip (stall) modes, with sticky error flags.
// PARAMETERS
// - DVP_DATA_W     8                      DVP byte width
// - PXL_INFO_W     DVP_DATA_W+2           FIFO entry: [PXL_INFO_W-1]=VSYNC, [PXL_INFO_W-2]=HSYNC, [DVP_DATA_W-1:0]=data
// - BYTES_PER_PXL  2                      bytes packed per pixel (1 = grayscale pass-through, 2 = RGB565)
// - PXL_W          DVP_DATA_W*BYTES_PER_PXL  output pixel width
// - FRAME_W        640                    expected pixels per line
// - FRAME_H        480                    expected lines per frame
// PORTS
// - clk              in   1           clock
// - rst              in   1           reset, synchronous, active-high
// - pxl_info_i       in   PXL_INFO_W  FIFO entry
// - pxl_info_vld_i   in   1           FIFO entry valid
// - pxl_info_rdy_o   out  1           FIFO entry consumed when vld & rdy
// - dcr_cam_start_i  in   1           level: capture enabled
// - dcr_snapshot_i   in   1           level: stop after one frame (sampled at frame start)
// - dcr_stall_i      in   1           level: skip frames (sampled at frame start)
// - err_clr_i        in   1           pulse: clear err_code_o
// - pxl_o            out  PXL_W       packed pixel, first byte in MSBs
// - pxl_vld_o        out  1           pixel valid, held until pxl_rdy_i
// - pxl_rdy_i        in   1           downstream ready
// - frame_done_o     out  1           1-cycle pulse per output frame end
// - err_code_o       out  2           sticky: [0] line length, [1] frame height
// BEHAVIOUR
// - Reset: state IDLE, pxl_o=0, pxl_vld_o=0, frame_done_o=0, err_code_o=0, all counters 0.
// - Handshake: entry consumed only on vld&rdy; pixel transfers on pxl_vld_o&pxl_rdy_i; pxl_o stable while vld & !rdy.
// - States: IDLE, WAIT_VS, VBLANK, FRAME, SKIP.
//   IDLE:    rdy=1, entries discarded; dcr_cam_start_i=1 -> WAIT_VS.
//   WAIT_VS: rdy=1, discard; entry with VSYNC=1 -> VBLANK. start=0 -> IDLE.
//   VBLANK:  rdy=1, discard VSYNC=1 entries; first VSYNC=0 entry = frame start: latch snapshot/stall;
//            start=0 -> IDLE; stall=1 -> SKIP; else -> FRAME and process that entry as FRAME would.
//   FRAME:   rdy = !(pxl_vld_o & !pxl_rdy_i). HSYNC=1 byte -> shifted into pack reg; on byte BYTES_PER_PXL
//            pxl_o loads, pxl_vld_o=1 next cycle (latency 1 from last byte accept); pixel counter +1.
//            HSYNC 1->0 (line end): pixel count != FRAME_W or partial pixel pending -> set err[0];
//            partial bytes dropped; line counter +1; pixel counter/byte index cleared.
//            VSYNC=1 entry (frame end): open line closed as above first; line count != FRAME_H -> set err[1];
//            frame_done_o pulses next cycle; counters cleared; snapshot latched or start=0 -> IDLE, else -> VBLANK.
//   SKIP:    rdy=1, discard, no checks, no frame_done_o; VSYNC=1 entry -> VBLANK.
// - Counters saturate at all-ones (no wrap); width $clog2(max(FRAME_W,FRAME_H)+1).
// - err_code_o bits sticky; err_clr_i clears; set in same cycle as clear wins (bit stays 1).
// - dcr_cam_start_i drop mid-FRAME: current frame completes, then IDLE; pending pixel still delivered.
// - rst mid-frame: everything returns to reset values in one cycle; pending pixel lost.
// - BYTES_PER_PXL=1: every HSYNC=1 byte is one pixel, byte index unused.
// CONFIGURATION
// - DVP_FRAME_CNT_EN defined: adds port frame_cnt_o out 16, count of frame_done_o pulses, reset 0,
//   wraps 0xFFFF->0, increments in the cycle frame_done_o is high.
// - Not defined: port absent, no counter logic; all other behaviour identical.
// TESTING
// - FRAME_W=4,FRAME_H=2,BPP=2; start=1, VS=1 then 2 lines of 8 bytes (0x11..0x88), VS=1 -> pixels 0x1122,0x3344,..; frame_done once; err=0.
// - Same frame, line 2 has 6 bytes -> 3 pixels on line 2, err_code_o=2'b01; err_clr_i -> 2'b00 next cycle.
// - 3 lines sent with FRAME_H=2 -> err_code_o=2'b10 at frame end; frame_done_o still pulses.
// - pxl_rdy_i=0 for 20 cycles mid-line -> pxl_o held constant, pxl_info_rdy_o=0, no byte lost after release.
// - dcr_snapshot_i=1, two frames sent -> only frame 1 output, FSM in IDLE; dcr_stall_i=1 at frame 2 start -> frame 2 skipped, frame 3 output.
// - rst asserted mid-line with pxl_vld_o=1 -> next cycle pxl_vld_o=0, err_code_o=0, state IDLE (frame_cnt_o=0 if DVP_FRAME_CNT_EN).

Source files
------------

// File: rtl/dvp_frame_ctrl.sv
// Frame-aware DVP receive controller: packs DVP bytes into pixels and checks line/frame geometry.
// Optional build macro DVP_FRAME_CNT_EN adds frame_cnt_o, a wrapping count of completed frames.
module dvp_frame_ctrl #(
  parameter int DVP_DATA_W    = 8,
  parameter int PXL_INFO_W    = DVP_DATA_W + 2,
  parameter int BYTES_PER_PXL = 2,
  parameter int PXL_W         = DVP_DATA_W * BYTES_PER_PXL,
  parameter int FRAME_W       = 640,
  parameter int FRAME_H       = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PXL_INFO_W-1:0] pxl_info_i,
  input  logic                  pxl_info_vld_i,
  output logic                  pxl_info_rdy_o,
  input  logic                  dcr_cam_start_i,
  input  logic                  dcr_snapshot_i,
  input  logic                  dcr_stall_i,
  input  logic                  err_clr_i,
  output logic [PXL_W-1:0]      pxl_o,
  output logic                  pxl_vld_o,
  input  logic                  pxl_rdy_i,
  output logic                  frame_done_o,
  output logic [1:0]            err_code_o
`ifdef DVP_FRAME_CNT_EN
  ,
  output logic [15:0]           frame_cnt_o
`endif
);

  localparam int MAX_DIM  = (FRAME_W > FRAME_H) ? FRAME_W : FRAME_H;
  localparam int CNT_W    = $clog2(MAX_DIM + 1);
  localparam int BIDX_W   = (BYTES_PER_PXL > 1) ? $clog2(BYTES_PER_PXL) : 1;
  localparam int PACK_W   = (BYTES_PER_PXL > 1) ? (BYTES_PER_PXL - 1) * DVP_DATA_W : DVP_DATA_W;
  localparam logic [CNT_W-1:0]  W_C      = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]  H_C      = CNT_W'(FRAME_H);
  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(BYTES_PER_PXL - 1);

  typedef enum logic [2:0] {IDLE, WAIT_VS, VBLANK, FRAME, SKIP} state_t;

  state_t              state_reg;
  logic [CNT_W-1:0]    pix_cnt_reg;
  logic [CNT_W-1:0]    line_cnt_reg;
  logic [BIDX_W-1:0]   byte_idx_reg;
  logic                line_open_reg;
  logic [PACK_W-1:0]   pack_reg;
  logic                snap_lat_reg;
  logic                snap_hold_reg;
  logic [PXL_W-1:0]    pxl_reg;
  logic                pxl_vld_reg;
  logic                frame_done_reg;
  logic [1:0]          err_reg;

  logic                  vsync;
  logic                  hsync;
  logic [DVP_DATA_W-1:0] data;
  logic                  blocked;
  logic                  rdy;
  logic                  accept;
  logic                  start_entry;
  logic                  proc;
  logic                  byte_evt;
  logic                  pxl_evt;
  logic                  line_end;
  logic                  frame_end;
  logic                  line_err;
  logic                  frame_err;
  logic [CNT_W-1:0]      line_cnt_new;
  logic [PACK_W-1:0]     pack_shift;
  logic [PXL_W-1:0]      new_pxl;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign vsync   = pxl_info_i[PXL_INFO_W-1];
  assign hsync   = pxl_info_i[PXL_INFO_W-2];
  assign data    = pxl_info_i[DVP_DATA_W-1:0];
  assign blocked = pxl_vld_reg && !pxl_rdy_i;

  generate
    if (BYTES_PER_PXL == 1) begin : g_bpp1
      assign new_pxl    = data;
      assign pack_shift = pack_reg;
    end else if (BYTES_PER_PXL == 2) begin : g_bpp2
      assign new_pxl    = {pack_reg, data};
      assign pack_shift = data;
    end else begin : g_bppn
      assign new_pxl    = {pack_reg, data};
      assign pack_shift = {pack_reg[PACK_W-DVP_DATA_W-1:0], data};
    end
  endgenerate

  // A frame-start entry in VBLANK may complete a pixel, so it must not overrun a stalled output.
  always_comb begin
    rdy = 1'b1;
    if (state_reg == FRAME)
      rdy = !blocked;
    else if (state_reg == VBLANK)
      rdy = !(pxl_info_vld_i && !vsync && blocked);
  end

  assign accept       = pxl_info_vld_i && rdy;
  assign start_entry  = accept && (state_reg == VBLANK) && !vsync && dcr_cam_start_i;
  assign proc         = (accept && (state_reg == FRAME)) || (start_entry && !dcr_stall_i);
  assign byte_evt     = proc && !vsync && hsync;
  assign pxl_evt      = byte_evt && (byte_idx_reg == LAST_IDX);
  assign line_end     = proc && line_open_reg && (vsync || !hsync);
  assign frame_end    = proc && vsync;
  assign line_err     = line_end && ((pix_cnt_reg != W_C) || (byte_idx_reg != '0));
  assign line_cnt_new = line_end ? sat_inc(line_cnt_reg) : line_cnt_reg;
  assign frame_err    = frame_end && (line_cnt_new != H_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      pix_cnt_reg    <= '0;
      line_cnt_reg   <= '0;
      byte_idx_reg   <= '0;
      line_open_reg  <= 1'b0;
      pack_reg       <= '0;
      snap_lat_reg   <= 1'b0;
      snap_hold_reg  <= 1'b0;
      pxl_reg        <= '0;
      pxl_vld_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
      err_reg        <= 2'b00;
    end else begin
      frame_done_reg <= frame_end;
      err_reg        <= (err_reg & {2{!err_clr_i}}) | {frame_err, line_err};

      if (pxl_evt) begin
        pxl_reg     <= new_pxl;
        pxl_vld_reg <= 1'b1;
      end else if (pxl_rdy_i) begin
        pxl_vld_reg <= 1'b0;
      end

      if (frame_end) begin
        pix_cnt_reg   <= '0;
        line_cnt_reg  <= '0;
        byte_idx_reg  <= '0;
        line_open_reg <= 1'b0;
      end else begin
        if (line_end) begin
          line_cnt_reg <= line_cnt_new;
          pix_cnt_reg  <= '0;
          byte_idx_reg <= '0;
        end
        if (byte_evt) begin
          pack_reg <= pack_shift;
          if (pxl_evt) begin
            byte_idx_reg <= '0;
            pix_cnt_reg  <= sat_inc(pix_cnt_reg);
          end else begin
            byte_idx_reg <= byte_idx_reg + 1'b1;
          end
        end
        if (proc)
          line_open_reg <= hsync;
      end

      // After a snapshot the controller parks in IDLE until capture is re-armed by dropping start.
      if (!dcr_cam_start_i)
        snap_hold_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (dcr_cam_start_i && !snap_hold_reg)
            state_reg <= WAIT_VS;
        end
        WAIT_VS: begin
          if (!dcr_cam_start_i)
            state_reg <= IDLE;
          else if (accept && vsync)
            state_reg <= VBLANK;
        end
        VBLANK: begin
          if (!dcr_cam_start_i) begin
            state_reg <= IDLE;
          end else if (start_entry) begin
            snap_lat_reg <= dcr_snapshot_i;
            state_reg    <= dcr_stall_i ? SKIP : FRAME;
          end
        end
        FRAME: begin
          if (frame_end) begin
            if (snap_lat_reg || !dcr_cam_start_i) begin
              state_reg <= IDLE;
              if (snap_lat_reg)
                snap_hold_reg <= 1'b1;
            end else begin
              state_reg <= VBLANK;
            end
          end
        end
        SKIP: begin
          if (accept && vsync)
            state_reg <= VBLANK;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef DVP_FRAME_CNT_EN
  logic [15:0] frame_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst)
      frame_cnt_reg <= '0;
    else if (frame_done_reg)
      frame_cnt_reg <= frame_cnt_reg + 16'd1;
  end

  assign frame_cnt_o = frame_cnt_reg;
`endif

  assign pxl_info_rdy_o = rdy;
  assign pxl_o          = pxl_reg;
  assign pxl_vld_o      = pxl_vld_reg;
  assign frame_done_o   = frame_done_reg;
  assign err_code_o     = err_reg;

endmodule

// File: tb/tb_dvp_frame_ctrl.sv
// Bench for dvp_frame_ctrl: frames are described as line lengths; a frame-level model predicts pixels and errors.
`timescale 1ns/1ps
module tb_dvp_frame_ctrl;
  localparam int DW  = 8;
  localparam int IW  = DW + 2;
  localparam int BPP = 2;
  localparam int PW  = DW * BPP;
  localparam int FW  = 4;
  localparam int FH  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] pxl_info_i;
  logic          pxl_info_vld_i;
  logic          pxl_info_rdy_o;
  logic          dcr_cam_start_i;
  logic          dcr_snapshot_i;
  logic          dcr_stall_i;
  logic          err_clr_i;
  logic [PW-1:0] pxl_o;
  logic          pxl_vld_o;
  logic          pxl_rdy_i;
  logic          frame_done_o;
  logic [1:0]    err_code_o;
`ifdef DVP_FRAME_CNT_EN
  logic [15:0]   frame_cnt_o;
`endif

  always #5 clk = ~clk;

  dvp_frame_ctrl #(
    .DVP_DATA_W(DW), .PXL_INFO_W(IW), .BYTES_PER_PXL(BPP),
    .PXL_W(PW), .FRAME_W(FW), .FRAME_H(FH)
  ) dut (
    .clk(clk), .rst(rst),
    .pxl_info_i(pxl_info_i), .pxl_info_vld_i(pxl_info_vld_i), .pxl_info_rdy_o(pxl_info_rdy_o),
    .dcr_cam_start_i(dcr_cam_start_i), .dcr_snapshot_i(dcr_snapshot_i),
    .dcr_stall_i(dcr_stall_i), .err_clr_i(err_clr_i),
    .pxl_o(pxl_o), .pxl_vld_o(pxl_vld_o), .pxl_rdy_i(pxl_rdy_i),
    .frame_done_o(frame_done_o), .err_code_o(err_code_o)
`ifdef DVP_FRAME_CNT_EN
    , .frame_cnt_o(frame_cnt_o)
`endif
  );

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [PW-1:0] exp_q[$];
  logic [1:0]    exp_err  = 2'b00;
  int            exp_done = 0;
  int            done_cnt = 0;
  int            xfer_cnt = 0;
  logic [PW-1:0] last_pxl = '0;
  bit            ds_ready = 1'b1;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  function automatic logic [7:0] bval(input logic [7:0] seed, input int j);
    return seed + 8'(8'h11 * (j + 1));
  endfunction

  // Frame-level model: each line of n bytes yields floor(n/2) pixels; geometry errors are sticky.
  task automatic model_frame(input int nl, input int len_last, input logic [7:0] seed);
    for (int l = 0; l < nl; l++) begin
      int len;
      len = (l == nl - 1) ? len_last : 2 * FW;
      for (int k = 0; k + 1 < len; k += 2)
        exp_q.push_back({bval(seed, k), bval(seed, k + 1)});
      if (len != 2 * FW) exp_err[0] = 1'b1;
    end
    if (nl != FH) exp_err[1] = 1'b1;
    exp_done++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic vs, input logic hs, input logic [7:0] d);
    int waited;
    waited = 0;
    @(negedge clk);
    pxl_info_i     = {vs, hs, d};
    pxl_info_vld_i = 1'b1;
    #1;
    while (!pxl_info_rdy_o && waited < 200) begin
      waited++;
      @(negedge clk);
      #1;
    end
    if (waited >= 200) begin
      check(1'b0, "entry_accept_timeout", 32'(waited), 32'd200);
      pxl_info_vld_i = 1'b0;
    end else begin
      @(posedge clk);
      #1 pxl_info_vld_i = 1'b0;
    end
  endtask

  task automatic send_frame(input int nl, input int len_last, input logic [7:0] seed, input bit out);
    $display("frame: lines=%0d last_len=%0d seed=%02h captured=%0d", nl, len_last, seed, out);
    if (out) model_frame(nl, len_last, seed);
    push(1'b1, 1'b0, 8'h00);
    push(1'b1, 1'b0, 8'h00);
    for (int l = 0; l < nl; l++) begin
      int len;
      len = (l == nl - 1) ? len_last : 2 * FW;
      for (int j = 0; j < len; j++) push(1'b0, 1'b1, bval(seed, j));
      push(1'b0, 1'b0, 8'h00);
      push(1'b0, 1'b0, 8'h00);
    end
    push(1'b1, 1'b0, 8'h00);
    idle(6);
  endtask

  // Downstream sink and the single output compare process.
  initial begin : cmp
    logic          held;
    logic [PW-1:0] held_val;
    logic [PW-1:0] e;
    held      = 1'b0;
    held_val  = '0;
    pxl_rdy_i = 1'b1;
    forever begin
      @(negedge clk);
      pxl_rdy_i = ds_ready;
      #2;
      if (rst) begin
        held = 1'b0;
        continue;
      end
      if (frame_done_o) done_cnt++;
      if (held) begin
        check(pxl_vld_o == 1'b1, "hold_vld", 32'(pxl_vld_o), 32'd1);
        check(pxl_o == held_val, "hold_pxl", 32'(pxl_o), 32'(held_val));
      end
      if (pxl_vld_o && pxl_rdy_i) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_pixel", 32'(pxl_o), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check(pxl_o == e, "pixel", 32'(pxl_o), 32'(e));
        end
        last_pxl = pxl_o;
        xfer_cnt++;
        held = 1'b0;
      end else if (pxl_vld_o) begin
        held     = 1'b1;
        held_val = pxl_o;
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_err();
    @(negedge clk);
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    #2;
    check(err_code_o == 2'b00, "err_clear", 32'(err_code_o), 32'd0);
    exp_err = 2'b00;
  endtask

  initial begin : main
    rst = 1'b1; pxl_info_i = '0; pxl_info_vld_i = 1'b0;
    dcr_cam_start_i = 1'b0; dcr_snapshot_i = 1'b0; dcr_stall_i = 1'b0; err_clr_i = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check(pxl_o == '0, "rst_pxl", 32'(pxl_o), 32'd0);
    check(pxl_vld_o == 1'b0, "rst_vld", 32'(pxl_vld_o), 32'd0);
    check(frame_done_o == 1'b0, "rst_done", 32'(frame_done_o), 32'd0);
    check(err_code_o == 2'b00, "rst_err", 32'(err_code_o), 32'd0);
    check(pxl_info_rdy_o == 1'b1, "rst_rdy", 32'(pxl_info_rdy_o), 32'd1);
`ifdef DVP_FRAME_CNT_EN
    check(frame_cnt_o == 16'd0, "rst_fcnt", 32'(frame_cnt_o), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    dcr_cam_start_i = 1'b1;
    idle(2);

    // Nominal frame
    send_frame(2, 8, 8'h00, 1'b1);
    check(exp_q.size() == 0, "f1_drain", 32'(exp_q.size()), 32'd0);
    check(last_pxl == 16'h7788, "f1_last_pxl", 32'(last_pxl), 32'h7788);
    check(err_code_o == 2'b00, "f1_err", 32'(err_code_o), 32'd0);
    check(done_cnt == 1, "f1_done", 32'(done_cnt), 32'd1);

    // Short second line
    send_frame(2, 6, 8'h00, 1'b1);
    check(exp_q.size() == 0, "f2_drain", 32'(exp_q.size()), 32'd0);
    check(last_pxl == 16'h5566, "f2_last_pxl", 32'(last_pxl), 32'h5566);
    check(err_code_o == 2'b01, "f2_err", 32'(err_code_o), 32'd1);
    check(err_code_o == exp_err, "f2_err_model", 32'(err_code_o), 32'(exp_err));
    clear_err();

    // Too many lines
    send_frame(3, 8, 8'h20, 1'b1);
    check(exp_q.size() == 0, "f3_drain", 32'(exp_q.size()), 32'd0);
    check(err_code_o == 2'b10, "f3_err", 32'(err_code_o), 32'd2);
    check(done_cnt == exp_done, "f3_done", 32'(done_cnt), 32'(exp_done));
    clear_err();

    // Downstream back-pressure for 20 cycles mid-line
    fork
      send_frame(2, 8, 8'h40, 1'b1);
      begin : bp
        int base;
        int g;
        base = xfer_cnt;
        g = 0;
        while (xfer_cnt < base + 2 && g < 300) begin
          @(negedge clk);
          g++;
        end
        check(g < 300, "bp_wait", 32'(g), 32'd300);
        ds_ready = 1'b0;
        repeat (20) @(negedge clk);
        #3;
        check(pxl_info_rdy_o == 1'b0, "bp_rdy", 32'(pxl_info_rdy_o), 32'd0);
        check(pxl_vld_o == 1'b1, "bp_vld", 32'(pxl_vld_o), 32'd1);
        ds_ready = 1'b1;
      end
    join
    idle(4);
    check(exp_q.size() == 0, "bp_drain", 32'(exp_q.size()), 32'd0);
    check(err_code_o == 2'b00, "bp_err", 32'(err_code_o), 32'd0);
    check(done_cnt == exp_done, "bp_done", 32'(done_cnt), 32'(exp_done));

    // Snapshot: only the first frame is captured
    dcr_snapshot_i = 1'b1;
    send_frame(2, 8, 8'h50, 1'b1);
    dcr_snapshot_i = 1'b0;
    send_frame(2, 8, 8'h60, 1'b0);
    check(exp_q.size() == 0, "snap_drain", 32'(exp_q.size()), 32'd0);
    check(done_cnt == exp_done, "snap_done", 32'(done_cnt), 32'(exp_done));
    check(pxl_info_rdy_o == 1'b1, "snap_idle_rdy", 32'(pxl_info_rdy_o), 32'd1);
    @(negedge clk);
    dcr_cam_start_i = 1'b0;
    idle(3);
    dcr_cam_start_i = 1'b1;
    idle(2);

    // Frame skip: middle frame (bad geometry) is ignored entirely
    send_frame(2, 8, 8'h70, 1'b1);
    dcr_stall_i = 1'b1;
    send_frame(3, 8, 8'h80, 1'b0);
    dcr_stall_i = 1'b0;
    send_frame(2, 8, 8'h90, 1'b1);
    check(exp_q.size() == 0, "skip_drain", 32'(exp_q.size()), 32'd0);
    check(done_cnt == exp_done, "skip_done", 32'(done_cnt), 32'(exp_done));
    check(err_code_o == 2'b00, "skip_err", 32'(err_code_o), 32'd0);

    // Reset mid-line with a pending pixel and a sticky error
    send_frame(1, 8, 8'hA0, 1'b1);
    check(err_code_o == 2'b10, "pre_rst_err", 32'(err_code_o), 32'd2);
    ds_ready = 1'b0;
    idle(1);
    push(1'b1, 1'b0, 8'h00);
    push(1'b0, 1'b1, 8'hAA);
    push(1'b0, 1'b1, 8'hBB);
    idle(2);
    #2;
    check(pxl_vld_o == 1'b1, "pre_rst_vld", 32'(pxl_vld_o), 32'd1);
    check(pxl_o == 16'hAABB, "pre_rst_pxl", 32'(pxl_o), 32'hAABB);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #2;
    check(pxl_vld_o == 1'b0, "rst2_vld", 32'(pxl_vld_o), 32'd0);
    check(err_code_o == 2'b00, "rst2_err", 32'(err_code_o), 32'd0);
    check(frame_done_o == 1'b0, "rst2_done", 32'(frame_done_o), 32'd0);
    check(pxl_info_rdy_o == 1'b1, "rst2_rdy", 32'(pxl_info_rdy_o), 32'd1);
    check(pxl_o == '0, "rst2_pxl", 32'(pxl_o), 32'd0);
`ifdef DVP_FRAME_CNT_EN
    check(frame_cnt_o == 16'd0, "rst2_fcnt", 32'(frame_cnt_o), 32'd0);
`endif
    exp_q.delete();
    exp_err = 2'b00;
    ds_ready = 1'b1;
    rst = 1'b0;
    idle(2);

    // Recovery after reset
    send_frame(2, 8, 8'hB0, 1'b1);
    check(exp_q.size() == 0, "rec_drain", 32'(exp_q.size()), 32'd0);
    check(err_code_o == 2'b00, "rec_err", 32'(err_code_o), 32'd0);
    check(done_cnt == exp_done, "rec_done", 32'(done_cnt), 32'(exp_done));
`ifdef DVP_FRAME_CNT_EN
    check(frame_cnt_o == 16'd1, "rec_fcnt", 32'(frame_cnt_o), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
